// File: rtl/pulse_count_reader_if.sv
// Bundles the FIFO read port and the byte-stream port of pulse_count_reader.
// The master modport is the reader itself; the slave modport is its surroundings.
interface pulse_count_reader_if;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [31:0] fifo_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  fifo_empty, fifo_dout, tx_ready,
        output fifo_rd, tx_data, tx_valid
    );

    modport slave (
        output fifo_empty, fifo_dout, tx_ready,
        input  fifo_rd, tx_data, tx_valid
    );
endinterface

// File: rtl/pulse_count_reader.sv
// Pops packed-BCD photon counts from a FIFO and streams each one as ASCII decimal,
// most significant digit first, with optional leading-zero suppression and CR LF.
module pulse_count_reader #(
    parameter bit SUPPRESS_LZ = 1'b1,
    parameter bit EOL_EN      = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    pulse_count_reader_if.master        bus,
    output logic                        busy,
    output logic                        bcd_err
);

    typedef enum logic [2:0] {IDLE, RD, CAP, SEND, CR, LF} state_e;

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;
    logic        lead_q, lead_d;
    logic        fifo_rd_q, fifo_rd_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        bcd_err_q, bcd_err_d;

    // Digit evaluation request: shared by CAP (first digit) and SEND (next digit).
    logic        ev_en;
    logic [31:0] ev_word;
    logic [2:0]  ev_idx;
    logic        ev_lead;
    logic [3:0]  ev_digit;

    function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] i);
        return w[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    function automatic logic has_bad_nibble(input logic [31:0] w);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (nibble(w, 3'(k)) > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        lead_d     = lead_q;
        fifo_rd_d  = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        bcd_err_d  = 1'b0;
        ev_en      = 1'b0;
        ev_word    = word_q;
        ev_idx     = idx_q;
        ev_lead    = lead_q;
        ev_digit   = 4'h0;

        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (en && !bus.fifo_empty) begin
                    state_d   = RD;
                    fifo_rd_d = 1'b1;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                word_d    = bus.fifo_dout;
                idx_d     = 3'd7;
                bcd_err_d = has_bad_nibble(bus.fifo_dout);
                state_d   = SEND;
                ev_en     = 1'b1;
                ev_word   = bus.fifo_dout;
                ev_idx    = 3'd7;
                ev_lead   = SUPPRESS_LZ;
            end
            SEND: begin
                // tx_valid low in SEND marks a skipped leading zero at idx_q.
                if (!tx_valid_q || bus.tx_ready) begin
                    if (tx_valid_q && idx_q == 3'd0) begin
                        if (EOL_EN) begin
                            state_d   = CR;
                            tx_data_d = 8'h0D;
                        end else begin
                            state_d    = IDLE;
                            tx_valid_d = 1'b0;
                        end
                    end else begin
                        idx_d  = idx_q - 3'd1;
                        ev_en  = 1'b1;
                        ev_idx = idx_q - 3'd1;
                    end
                end
            end
            CR: begin
                if (bus.tx_ready) begin
                    state_d   = LF;
                    tx_data_d = 8'h0A;
                end
            end
            LF: begin
                if (bus.tx_ready) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // A nibble above 9 is printed as '?' and ends the leading-zero run.
        if (ev_en) begin
            ev_digit = nibble(ev_word, ev_idx);
            if (ev_lead && ev_digit == 4'h0 && ev_idx != 3'd0) begin
                tx_valid_d = 1'b0;
                lead_d     = 1'b1;
            end else begin
                tx_valid_d = 1'b1;
                tx_data_d  = to_ascii(ev_digit);
                lead_d     = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            // NOTE: the word register is cleared too, so a discarded word never lingers after reset.
            word_q     <= '0;
            idx_q      <= '0;
            lead_q     <= 1'b0;
            fifo_rd_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            bcd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            lead_q     <= lead_d;
            fifo_rd_q  <= fifo_rd_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            bcd_err_q  <= bcd_err_d;
        end
    end

    assign bus.fifo_rd  = fifo_rd_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy         = busy_q;
    assign bcd_err      = bcd_err_q;

endmodule
